// File: rtl/rv0_pkg.sv
// Shared definitions for the rv0 skid-buffer FIFO: the minimum legal
// depth and the helper that sizes the occupancy counter.
package rv0_pkg;

    // Smallest entry count the FIFO supports.
    localparam int RV0_SBUF_MIN_DEPTH = 2;

    // Width of rv0_sbuf_cnt_t: enough bits to hold 0..depth inclusive,
    // so that full and empty are distinguished by the count alone.
    function automatic int rv0_sbuf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : rv0_pkg

// File: rtl/rv0_sbuf_ptr.sv
// Modulo-DEPTH wrap counter used for both FIFO pointers. It wraps from
// DEPTH-1 to 0 for any DEPTH, not only for powers of two. A clear takes
// priority over an increment.
module rv0_sbuf_ptr #(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    // Next pointer: clear, wrap at DEPTH-1, or step by one.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : rv0_sbuf_ptr

// File: rtl/rv0_sbuf_fifo.sv
// rv0_sbuf_fifo: DEPTH-entry FIFO with registered occupancy count.
// Optional macro RV0_SBUF_FIFO_BYPASS_EN lets a beat flow straight
// through while the FIFO is empty; without it, outputs depend only on
// flops.
//
// Handshake: a beat moves on a rising edge when the sender's valid and
// the receiver's ready are both 1 in that cycle. Upstream valid is
// rdy_i, upstream ready is ack_o; downstream valid is rdy_o, downstream
// ready is ack_i. ack_o never depends on ack_i, so a full FIFO refuses
// a push even while it is being popped; ack_o rises the cycle after.
module rv0_sbuf_fifo
    import rv0_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [WIDTH-1:0]                     data_i,
    input  logic                                 rdy_i,
    output logic                                 ack_o,
    output logic [WIDTH-1:0]                     data_o,
    output logic                                 rdy_o,
    input  logic                                 ack_i,
    output logic [rv0_sbuf_cnt_w(DEPTH)-1:0]     count_o
);

    localparam int CNT_W = rv0_sbuf_cnt_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [CNT_W-1:0] rv0_sbuf_cnt_t;

    if (DEPTH < RV0_SBUF_MIN_DEPTH) begin : g_bad_depth
        $error("rv0_sbuf_fifo: DEPTH below minimum");
    end

    rv0_sbuf_cnt_t    count_d;
    rv0_sbuf_cnt_t    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    logic empty;
    logic byp_act;
    logic wr_en;
    logic rd_en;

    // Handshake decode: which of store, drain and pass-through happen.
    always_comb begin
        empty = (count_q == '0);
        ack_o = (count_q != rv0_sbuf_cnt_t'(DEPTH));
`ifdef RV0_SBUF_FIFO_BYPASS_EN
        byp_act = empty & rdy_i & ~flush_i;
`else
        byp_act = 1'b0;
`endif
        // A bypassed beat that is taken downstream is never stored.
        wr_en = rdy_i & ack_o & ~flush_i & ~(byp_act & ack_i);
        rd_en = ~empty & ack_i & ~flush_i;
    end

    // Occupancy update; flush wins over any push or pop.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (wr_en && !rd_en) begin
            count_d = count_q + rv0_sbuf_cnt_t'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - rv0_sbuf_cnt_t'(1);
        end
    end

    // Occupancy register, discarded asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage, written only on an accepted push; no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr] <= data_i;
        end
    end

    rv0_sbuf_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (wr_en),
        .ptr_o  (wptr)
    );

    rv0_sbuf_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (rd_en),
        .ptr_o  (rptr)
    );

    // Downstream view: head entry, pass-through beat, or RST_DATA when empty.
    always_comb begin
        rdy_o  = ~empty | byp_act;
        data_o = RST_DATA;
        if (byp_act) begin
            data_o = data_i;
        end else if (!empty) begin
            data_o = mem_q[rptr];
        end
    end

    assign count_o = count_q;

endmodule : rv0_sbuf_fifo

// File: tb/tb_rv0_sbuf_fifo.sv
// Directed bench for rv0_sbuf_fifo: a DEPTH=2 instance (A) and a DEPTH=3
// instance (B, non-zero RST_DATA) share clock and reset.
module tb_rv0_sbuf_fifo;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hA5A5_0000;
`ifdef RV0_SBUF_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic        a_flush, a_rdy_i, a_ack_i, a_ack_o, a_rdy_o;
    logic [31:0] a_data_i, a_data_o;
    logic [1:0]  a_count;

    logic        b_flush, b_rdy_i, b_ack_i, b_ack_o, b_rdy_o;
    logic [31:0] b_data_i, b_data_o;
    logic [1:0]  b_count;

    int n_cmp;
    int n_err;

    logic [31:0] exp_q[$];

    rv0_sbuf_fifo #(.WIDTH(32), .DEPTH(2), .RST_DATA(RST_A)) u_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (a_flush),
        .data_i  (a_data_i),
        .rdy_i   (a_rdy_i),
        .ack_o   (a_ack_o),
        .data_o  (a_data_o),
        .rdy_o   (a_rdy_o),
        .ack_i   (a_ack_i),
        .count_o (a_count)
    );

    rv0_sbuf_fifo #(.WIDTH(32), .DEPTH(3), .RST_DATA(RST_B)) u_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (b_flush),
        .data_i  (b_data_i),
        .rdy_i   (b_rdy_i),
        .ack_o   (b_ack_o),
        .data_o  (b_data_o),
        .rdy_o   (b_rdy_o),
        .ack_i   (b_ack_i),
        .count_o (b_count)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard compare
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_push;
        int n_pop;
        int pops_at_last_push;
        int push_cycles;
        int c;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_flush = 0; a_rdy_i = 0; a_ack_i = 0; a_data_i = '0;
        b_flush = 0; b_rdy_i = 0; b_ack_i = 0; b_data_i = '0;

        // Reset state
        #2;
        check_eq("rst_a_count", 32'(a_count), 0);
        check_eq("rst_a_rdy_o", 32'(a_rdy_o), 0);
        check_eq("rst_a_ack_o", 32'(a_ack_o), 1);
        check_eq("rst_a_data_o", a_data_o, RST_A);
        check_eq("rst_b_data_o", b_data_o, RST_B);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three pushes into DEPTH=2 with the sink stalled
        cyc();
        a_rdy_i = 1; a_data_i = 32'h11; a_ack_i = 0;
        settle();
        check_eq("s1_ack_empty", 32'(a_ack_o), 1);
        cyc();
        a_data_i = 32'h22;
        settle();
        check_eq("s1_count1", 32'(a_count), 1);
        check_eq("s1_rdy_o", 32'(a_rdy_o), 1);
        check_eq("s1_head", a_data_o, 32'h11);
        cyc();
        a_data_i = 32'h33;
        settle();
        check_eq("s1_count2", 32'(a_count), 2);
        check_eq("s1_ack_full", 32'(a_ack_o), 0);
        cyc();
        settle();
        check_eq("s1_held_count", 32'(a_count), 2);
        check_eq("s1_held_head", a_data_o, 32'h11);

        // Full with push and pop offered together: pop only
        a_ack_i = 1;
        settle();
        check_eq("s3_ack_full", 32'(a_ack_o), 0);
        cyc();
        a_rdy_i = 0; a_ack_i = 0;
        settle();
        check_eq("s3_count", 32'(a_count), 1);
        check_eq("s3_ack_next", 32'(a_ack_o), 1);
        check_eq("s3_head", a_data_o, 32'h22);

        // Flush with push and pop at count=1
        a_flush = 1; a_rdy_i = 1; a_data_i = 32'h44; a_ack_i = 1;
        settle();
        cyc();
        a_flush = 0; a_rdy_i = 0; a_ack_i = 0;
        settle();
        check_eq("s4_count", 32'(a_count), 0);
        check_eq("s4_rdy_o", 32'(a_rdy_o), 0);
        check_eq("s4_data_o", a_data_o, RST_A);
        a_rdy_i = 1; a_data_i = 32'h55;
        settle();
        cyc();
        a_rdy_i = 0;
        settle();
        check_eq("s4_after_count", 32'(a_count), 1);
        check_eq("s4_after_head", a_data_o, 32'h55);
        a_ack_i = 1;
        settle();
        cyc();
        a_ack_i = 0;
        settle();
        check_eq("s4_drained", 32'(a_count), 0);

`ifdef RV0_SBUF_FIFO_BYPASS_EN
        // Pass-through while empty
        a_data_i = 32'hDEAD_BEEF; a_rdy_i = 1; a_ack_i = 1;
        settle();
        check_eq("byp_rdy_o", 32'(a_rdy_o), 1);
        check_eq("byp_data_o", a_data_o, 32'hDEAD_BEEF);
        cyc();
        a_rdy_i = 0; a_ack_i = 0;
        settle();
        check_eq("byp_count", 32'(a_count), 0);
`endif

        // Stream 100 beats through DEPTH=3
        n_push = 0;
        n_pop = 0;
        pops_at_last_push = -1;
        push_cycles = 0;
        c = 0;
        while (n_pop < 100 && c < 300) begin
            b_ack_i = 1;
            if (n_push < 100) begin
                b_rdy_i = 1;
                b_data_i = 32'h1000_0000 + 32'(n_push);
            end else begin
                b_rdy_i = 0;
            end
            settle();
            if (b_rdy_i && b_ack_o) begin
                exp_q.push_back(b_data_i);
                n_push++;
            end
            if (b_rdy_o && b_ack_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("s2_underflow", b_data_o, 32'hFFFF_FFFF);
                end else begin
                    check_eq("s2_order", b_data_o, exp_q.pop_front());
                end
                n_pop++;
            end
            if (n_push == 100 && pops_at_last_push < 0) begin
                pops_at_last_push = n_pop;
                push_cycles = c + 1;
            end
            c++;
            cyc();
        end
        b_rdy_i = 0; b_ack_i = 0;
        settle();
        check_eq("s2_pops", 32'(n_pop), 100);
        check_eq("s2_push_cycles", 32'(push_cycles), 100);
        check_eq("s2_rate", 32'(pops_at_last_push), BYP ? 100 : 99);
        check_eq("s2_left", 32'(exp_q.size()), 0);
        check_eq("s2_count", 32'(b_count), 0);

        // Reset mid-stream at count=2
        a_rdy_i = 1; a_data_i = 32'h66; b_rdy_i = 1; b_data_i = 32'h166;
        settle();
        cyc();
        a_data_i = 32'h77; b_data_i = 32'h177;
        settle();
        cyc();
        a_rdy_i = 0; b_rdy_i = 0;
        settle();
        check_eq("s5_a_count", 32'(a_count), 2);
        check_eq("s5_b_count", 32'(b_count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s5_a_rdy_o", 32'(a_rdy_o), 0);
        check_eq("s5_a_data_o", a_data_o, RST_A);
        check_eq("s5_a_count0", 32'(a_count), 0);
        check_eq("s5_a_ack_o", 32'(a_ack_o), 1);
        check_eq("s5_b_rdy_o", 32'(b_rdy_o), 0);
        check_eq("s5_b_data_o", b_data_o, RST_B);
        #1;
        rst_n = 1'b1;

        // First push on the first edge after reset release
        a_rdy_i = 1; a_data_i = 32'h88;
        cyc();
        a_rdy_i = 0;
        settle();
        check_eq("s5_first_push", 32'(a_count), 1);
        check_eq("s5_first_head", a_data_o, 32'h88);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rv0_sbuf_fifo

// File: doc/rv0_sbuf_fifo.md
RV0_SBUF_FIFO -- requirements
Module: rv0_sbuf_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, entry count (>=2; non-power-of-two legal).
REQ-003 SHALL have parameter RST_DATA, default '0, value of data_o while empty or in reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: ports clk_i and rst_ni.
REQ-005 clk_i  input  1  clock, all state rising-edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 flush_i  input  1  discard all entries.
REQ-008 data_i  input  WIDTH  upstream payload.
REQ-009 rdy_i  input  1  upstream valid.
REQ-010 ack_o  output  1  upstream ready.
REQ-011 data_o  output  WIDTH  head payload.
REQ-012 rdy_o  output  1  downstream valid.
REQ-013 ack_i  input  1  downstream ready.
REQ-014 count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Push SHALL occur on a rising edge with rdy_i=1 and ack_o=1; pop SHALL occur with rdy_o=1 and ack_i=1.
REQ-016 ack_o SHALL equal (count != DEPTH), decoded only from registered count, with no combinational path from ack_i.
REQ-017 rdy_o SHALL equal (count != 0) without the bypass feature; data_o SHALL be the entry at the read pointer, or RST_DATA when empty.
REQ-018 Baseline latency SHALL be 1 cycle from push to rdy_o=1; throughput SHALL be 1 beat/cycle when both sides are streaming.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, not only at powers of two.
REQ-020 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and preserve order.
REQ-021 When full, a push SHALL NOT be accepted even if a pop occurs that cycle; ack_o rises on the following cycle.
REQ-022 When empty, a pop SHALL NOT occur (rdy_o=0) unless the bypass feature applies.
REQ-023 flush_i=1 SHALL zero count and both pointers at the next edge, override any push or pop in that cycle, and drop the beat offered that cycle.
REQ-024 The relation count = (wptr - rptr) mod DEPTH, with full distinguished by count, SHALL hold at all times.
REQ-025 Storage SHALL be written only on push; payload flops SHALL need no reset.

Reset
REQ-026 In reset: count_o=0, rdy_o=0, ack_o=1, data_o=RST_DATA, pointers=0.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).
REQ-028 The first push SHALL be possible on the first edge after deassertion.

Configuration
REQ-029 Macro RV0_SBUF_FIFO_BYPASS_EN SHALL select the bypass feature.
REQ-030 With the macro defined, when count=0, rdy_i=1 and flush_i=0: rdy_o=1 and data_o=data_i combinationally; if ack_i=1 the beat SHALL pass without being stored and count stays 0.
REQ-031 Without the macro, there SHALL be no combinational path from the input ports to the output ports.

Structure
REQ-032 Package rv0_pkg SHALL hold the rv0_sbuf_cnt_t width helper and the minimum-depth constant RV0_SBUF_MIN_DEPTH=2.
REQ-033 Sub-module rv0_sbuf_ptr (modulo-DEPTH wrap counter with increment and clear) SHALL be instantiated for both the read and write pointers.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Reset, then 3 pushes with ack_i=0 and DEPTH=2 -> count_o=2, ack_o=0 after the 2nd push, and the 3rd beat is held upstream.
- Streaming 100 beats with rdy_i=ack_i=1 and DEPTH=3 -> output order matches input, one beat/cycle after the first, and pointers wrap 2->0.
- Full with push and pop in the same cycle -> pop only, count 2->1, ack_o=1 on the next cycle.
- flush_i together with push and pop at count=1 -> count_o=0 and rdy_o=0 on the next cycle, and the offered beat is lost.
- rst_ni low mid-stream at count=2 -> rdy_o=0 and data_o=RST_DATA immediately, with no clock required.
- With the bypass macro, empty, data_i=32'hDEAD_BEEF, rdy_i=ack_i=1 -> data_o=32'hDEAD_BEEF the same cycle and count stays 0.
